// File: rtl/jesd_sysref_pkg.sv
// Shared SYSREF/LMFC definitions used by both the SYSREF generator and
// the receive-side LMFC aligner so both ends derive the same period.
package jesd_sysref_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ALIGNED = 2'd2
    } lmfc_state_e;

    // LMFC period in core clocks: K frames of F octets, 4 octets per clock.
    function automatic int lmfc_period(input int k, input int f);
        return (k * f) / 4;
    endfunction

endpackage

// File: rtl/sysref_edge_det.sv
// SYSREF rising-edge detector.
// Ports: clock, rst (sync, active-high), sysref in; sysref_edge out (comb).
module sysref_edge_det (
    input  logic clock,
    input  logic rst,
    input  logic sysref,
    output logic sysref_edge
);

    logic sysref_q;
    logic sysref_d;

    always_comb begin
        sysref_d = sysref;
    end

    // Reset value 1 so a SYSREF already high at reset release is not an edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            sysref_q <= 1'b1;
        end else begin
            sysref_q <= sysref_d;
        end
    end

    assign sysref_edge = sysref & ~sysref_q;

endmodule

// File: rtl/sysref_lmfc_align.sv
// Receive-side LMFC aligner: locks a free-running LMFC counter to SYSREF,
// drives SYNC~ after CGS, and flags/counts misaligned SYSREF edges.
// Ports: clock, rst, arm, sysref, realign, cgs_done in;
//        lmfc_pulse, lmfc_cnt, aligned, sync_n, sysref_err, err_cnt out.
module sysref_lmfc_align
    import jesd_sysref_pkg::*;
#(
    parameter int F     = 4,
    parameter int K     = 32,
    parameter int CNT_W = 9
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 sysref,
    input  logic                 realign,
    input  logic                 cgs_done,
    output logic                 lmfc_pulse,
    output logic [CNT_W-1:0]     lmfc_cnt,
    output logic                 aligned,
    output logic                 sync_n,
    output logic                 sysref_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PERIOD = lmfc_period(K, F);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    if (PERIOD < 2 || PERIOD > (1 << CNT_W)) begin : g_bad_period
        $error("sysref_lmfc_align: PERIOD out of range for CNT_W");
    end

    lmfc_state_e          state_q, state_d;
    logic [CNT_W-1:0]     lmfc_cnt_q, lmfc_cnt_d;
    logic                 lmfc_pulse_q, lmfc_pulse_d;
    logic                 aligned_q, aligned_d;
    logic                 sync_n_q, sync_n_d;
    logic                 sysref_err_q, sysref_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 sysref_edge;
    logic                 cnt_zero;

    sysref_edge_det u_edge (
        .clock       (clock),
        .rst         (rst),
        .sysref      (sysref),
        .sysref_edge (sysref_edge)
    );

    assign cnt_zero = (lmfc_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        lmfc_cnt_d   = cnt_zero ? LAST : lmfc_cnt_q - 1'b1;
        lmfc_pulse_d = cnt_zero;
        aligned_d    = aligned_q;
        sync_n_d     = sync_n_q;
        sysref_err_d = 1'b0;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                aligned_d = 1'b0;
                sync_n_d  = 1'b0;
                if (arm) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                sync_n_d = 1'b0;
                if (!arm) begin
                    state_d   = IDLE;
                    aligned_d = 1'b0;
                end else if (sysref_edge) begin
                    state_d    = ALIGNED;
                    lmfc_cnt_d = LAST;
                    aligned_d  = 1'b1;
                end
            end
            ALIGNED: begin
                if (!arm) begin
                    state_d   = IDLE;
                    aligned_d = 1'b0;
                    sync_n_d  = 1'b0;
                end else begin
                    // An in-phase edge lands on cnt==0, where the natural
                    // wrap already reloads LAST, so only off-phase edges act.
                    if (sysref_edge && !cnt_zero) begin
                        sysref_err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (realign) begin
                            lmfc_cnt_d = LAST;
                        end
                    end
                    // Release lines up with the registered lmfc_pulse.
                    if (!cgs_done) begin
                        sync_n_d = 1'b0;
                    end else if (cnt_zero) begin
                        sync_n_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            lmfc_cnt_q   <= LAST;
            lmfc_pulse_q <= 1'b0;
            aligned_q    <= 1'b0;
            sync_n_q     <= 1'b0;
            sysref_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            lmfc_cnt_q   <= lmfc_cnt_d;
            lmfc_pulse_q <= lmfc_pulse_d;
            aligned_q    <= aligned_d;
            sync_n_q     <= sync_n_d;
            sysref_err_q <= sysref_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign lmfc_pulse = lmfc_pulse_q;
    assign lmfc_cnt   = lmfc_cnt_q;
    assign aligned    = aligned_q;
    assign sync_n     = sync_n_q;
    assign sysref_err = sysref_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sysref_lmfc_align.sv
// Self-checking bench for sysref_lmfc_align (K=32, F=4, PERIOD=32).
// Expected values are queued per cycle and compared as the DUT reaches them.
module tb_sysref_lmfc_align;

    localparam int CW = 9;

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          sysref = 1'b0;
    logic          realign = 1'b0;
    logic          cgs_done = 1'b0;
    logic          lmfc_pulse;
    logic [CW-1:0] lmfc_cnt;
    logic          aligned;
    logic          sync_n;
    logic          sysref_err;
    logic [7:0]    err_cnt;

    typedef enum int {S_PULSE, S_CNT, S_ALIGNED, S_SYNC, S_ERR, S_ERRCNT} sig_e;
    typedef struct {
        int    cyc;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   total;
    int   bad;

    sysref_lmfc_align #(.F(4), .K(32), .CNT_W(CW)) dut (
        .clock      (clock),
        .rst        (rst),
        .arm        (arm),
        .sysref     (sysref),
        .realign    (realign),
        .cgs_done   (cgs_done),
        .lmfc_pulse (lmfc_pulse),
        .lmfc_cnt   (lmfc_cnt),
        .aligned    (aligned),
        .sync_n     (sync_n),
        .sysref_err (sysref_err),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic exp_at(input int c, input sig_e s, input int v, input string n);
        sb.push_back('{c, s, v, n});
    endtask

    function automatic logic [31:0] obs(input sig_e s);
        case (s)
            S_PULSE:   return {31'd0, lmfc_pulse};
            S_CNT:     return {23'd0, lmfc_cnt};
            S_ALIGNED: return {31'd0, aligned};
            S_SYNC:    return {31'd0, sync_n};
            S_ERR:     return {31'd0, sysref_err};
            S_ERRCNT:  return {24'd0, err_cnt};
            default:   return 'x;
        endcase
    endfunction

    task automatic reset_dut(input logic sref);
        rst = 1'b1;
        arm = 1'b0;
        sysref = sref;
        realign = 1'b0;
        cgs_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset_dut(1'b0);
        exp_at(0, S_CNT, 31, "rst_cnt");
        exp_at(0, S_PULSE, 0, "rst_pulse");
        exp_at(0, S_ALIGNED, 0, "rst_aligned");
        exp_at(0, S_SYNC, 0, "rst_sync_n");
        exp_at(0, S_ERR, 0, "rst_err");
        exp_at(0, S_ERRCNT, 0, "rst_err_cnt");
        exp_at(3, S_CNT, 28, "idle_freerun_cnt");
        exp_at(3, S_ALIGNED, 0, "idle_aligned");
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                total++;
                if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                    bad++;
                    $display("FAIL %s @%0d: got %0d want %0d",
                             sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
        while (cyc < 3) begin
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL reset_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_align_sync();
        reset_dut(1'b0);
        arm = 1'b1;
        exp_at(10, S_ALIGNED, 0, "pre_edge_aligned");
        exp_at(11, S_ALIGNED, 1, "align_aligned");
        exp_at(11, S_CNT, 31, "align_cnt");
        exp_at(42, S_CNT, 0, "align_cnt_zero");
        exp_at(42, S_PULSE, 0, "pulse_before");
        exp_at(43, S_PULSE, 1, "pulse_43");
        exp_at(44, S_PULSE, 0, "pulse_one_cycle");
        exp_at(43, S_SYNC, 0, "sync_no_cgs");
        exp_at(50, S_CNT, 24, "cnt_50");
        exp_at(74, S_SYNC, 0, "sync_before_lmfc");
        exp_at(75, S_PULSE, 1, "pulse_75");
        exp_at(75, S_SYNC, 1, "sync_release");
        exp_at(80, S_SYNC, 1, "sync_hold");
        exp_at(90, S_SYNC, 1, "sync_hold_90");
        exp_at(91, S_SYNC, 0, "sync_drop");
        exp_at(107, S_PULSE, 1, "pulse_107");
        exp_at(107, S_SYNC, 0, "sync_stay_low");
        while (cyc < 110) begin
            sysref = (cyc == 10);
            if (cyc == 50) cgs_done = 1'b1;
            if (cyc == 90) cgs_done = 1'b0;
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL align_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_inphase();
        reset_dut(1'b0);
        arm = 1'b1;
        realign = 1'b1;
        exp_at(43, S_ERR, 0, "inph_err_43");
        exp_at(43, S_CNT, 31, "inph_cnt_43");
        exp_at(75, S_ERR, 0, "inph_err_75");
        exp_at(75, S_CNT, 31, "inph_cnt_75");
        exp_at(76, S_ERR, 0, "held_high_err");
        exp_at(76, S_CNT, 30, "held_high_cnt");
        exp_at(107, S_ERR, 0, "inph_err_107");
        exp_at(107, S_CNT, 31, "inph_cnt_107");
        exp_at(110, S_ERRCNT, 0, "inph_err_cnt");
        exp_at(110, S_ALIGNED, 1, "inph_aligned");
        while (cyc < 110) begin
            sysref = (cyc == 10) || (cyc == 42) || (cyc == 74) ||
                     (cyc == 75) || (cyc == 106);
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL inphase_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_misalign();
        reset_dut(1'b0);
        arm = 1'b1;
        exp_at(38, S_ERR, 1, "mis_err");
        exp_at(38, S_ERRCNT, 1, "mis_err_cnt");
        exp_at(38, S_CNT, 4, "mis_cnt_kept");
        exp_at(39, S_ERR, 0, "mis_err_pulse");
        exp_at(43, S_PULSE, 1, "mis_phase_kept");
        exp_at(70, S_CNT, 31, "realign_cnt");
        exp_at(70, S_ERR, 1, "realign_err");
        exp_at(70, S_ERRCNT, 2, "realign_err_cnt");
        exp_at(71, S_ERR, 0, "realign_err_pulse");
        exp_at(75, S_PULSE, 0, "old_phase_gone");
        exp_at(101, S_CNT, 0, "new_phase_zero");
        exp_at(102, S_PULSE, 1, "new_phase_pulse");
        while (cyc < 105) begin
            sysref = (cyc == 10) || (cyc == 37) || (cyc == 69);
            realign = (cyc >= 60);
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL misalign_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_saturate();
        reset_dut(1'b0);
        arm = 1'b1;
        realign = 1'b1;
        exp_at(13, S_ERRCNT, 1, "sat_first");
        exp_at(519, S_ERRCNT, 254, "sat_254");
        exp_at(521, S_ERRCNT, 255, "sat_255");
        exp_at(523, S_ERRCNT, 255, "sat_hold");
        exp_at(523, S_ERR, 1, "sat_err_still");
        exp_at(611, S_ERR, 1, "sat_last_err");
        exp_at(620, S_ERRCNT, 255, "sat_final");
        while (cyc < 620) begin
            sysref = (cyc == 10) ||
                     (cyc >= 12 && cyc <= 610 && (cyc % 2) == 0);
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL saturate_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_boundaries();
        reset_dut(1'b1);
        arm = 1'b1;
        exp_at(5, S_ALIGNED, 0, "held_high_no_edge");
        exp_at(20, S_ALIGNED, 0, "held_high_wait");
        exp_at(20, S_CNT, 11, "held_high_cnt");
        exp_at(26, S_ALIGNED, 1, "late_edge_aligned");
        exp_at(26, S_CNT, 31, "late_edge_cnt");
        exp_at(26, S_SYNC, 0, "late_edge_sync");
        exp_at(31, S_ALIGNED, 0, "disarm_aligned");
        exp_at(41, S_ALIGNED, 0, "arm_drop_edge");
        exp_at(41, S_CNT, 16, "arm_drop_cnt");
        exp_at(51, S_ALIGNED, 0, "idle_edge_aligned");
        exp_at(51, S_CNT, 6, "idle_edge_cnt");
        while (cyc < 55) begin
            sysref = (cyc < 20) || (cyc == 25) || (cyc == 40) || (cyc == 50);
            arm = (cyc < 30) || (cyc >= 33 && cyc < 40);
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL boundary_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        reset_dut(1'b0);
        arm = 1'b1;
        cgs_done = 1'b1;
        exp_at(43, S_SYNC, 1, "mid_sync_up");
        exp_at(46, S_ERR, 1, "mid_err");
        exp_at(74, S_ERRCNT, 1, "mid_err_cnt");
        exp_at(74, S_SYNC, 1, "mid_sync_74");
        exp_at(75, S_CNT, 31, "mid_rst_cnt");
        exp_at(75, S_PULSE, 0, "mid_rst_pulse");
        exp_at(75, S_ALIGNED, 0, "mid_rst_aligned");
        exp_at(75, S_SYNC, 0, "mid_rst_sync");
        exp_at(75, S_ERR, 0, "mid_rst_err");
        exp_at(75, S_ERRCNT, 0, "mid_rst_err_cnt");
        exp_at(76, S_CNT, 30, "mid_after_cnt");
        exp_at(76, S_ALIGNED, 0, "mid_after_aligned");
        while (cyc < 78) begin
            sysref = (cyc == 10) || (cyc == 45);
            rst = (cyc == 74);
            step();
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    if (obs(sb[i].sig) !== 32'(sb[i].val)) begin
                        bad++;
                        $display("FAIL %s @%0d: got %0d want %0d",
                                 sb[i].name, cyc, obs(sb[i].sig), sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_leftover: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        test_reset();
        test_align_sync();
        test_inphase();
        test_misalign();
        test_saturate();
        test_boundaries();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
